// File: rtl/sb_tx_msg_scheduler.sv
// Sideband TX message scheduler.
// Shares one sideband encoder between the LTSM and RDI message requesters.
// Arbitration is round-robin. Each grant produces one issue strobe with held
// fields. The FSM then waits for framing to report the packet sent, and
// enforces an idle gap before the next issue. A watchdog frees the slot if
// framing never reports completion.
//
// Handshake: a requester raises req with stable fields and holds it until its
// ack pulses for one cycle. Fields are captured only at grant. The encoder
// sees o_msg_valid for exactly one cycle. The fields stay held until the next
// grant. i_frame_done is a single-cycle pulse and is honoured only in
// WAIT_DONE.
module sb_tx_msg_scheduler #(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ltsm_req,
    input  logic [3:0]  i_ltsm_state,
    input  logic [3:0]  i_ltsm_sub_state,
    input  logic [3:0]  i_ltsm_msg_no,
    input  logic        i_ltsm_data_valid,
    input  logic [15:0] i_ltsm_data_bus,
    output logic        o_ltsm_ack,
    input  logic        i_rdi_req,
    input  logic [3:0]  i_rdi_msg_no,
    output logic        o_rdi_ack,
    output logic        o_msg_valid,
    output logic        o_data_valid,
    output logic [3:0]  o_state,
    output logic [3:0]  o_sub_state,
    output logic [3:0]  o_msg_no,
    output logic [15:0] o_data_bus,
    input  logic        i_frame_done,
    output logic        o_busy,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] TO_LD  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_last_grant_rdi;  // 1: RDI was served last
    logic               r_grant_rdi;       // requester owning the current slot
    logic               r_ltsm_ack;
    logic               r_rdi_ack;
    logic               r_msg_valid;
    logic               r_data_valid;
    logic [3:0]         r_state_f;
    logic [3:0]         r_sub_state;
    logic [3:0]         r_msg_no;
    logic [15:0]        r_data_bus;
    logic               r_busy;
    logic               r_timeout;

    logic               w_any_req;
    logic               w_grant_ltsm;

    // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
    assign w_any_req    = i_ltsm_req | i_rdi_req;
    assign w_grant_ltsm = i_ltsm_req & (~i_rdi_req | r_last_grant_rdi);

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_last_grant_rdi <= 1'b1;
            r_grant_rdi      <= 1'b0;
            r_ltsm_ack       <= 1'b0;
            r_rdi_ack        <= 1'b0;
            r_msg_valid      <= 1'b0;
            r_data_valid     <= 1'b0;
            r_state_f        <= 4'd0;
            r_sub_state      <= 4'd0;
            r_msg_no         <= 4'd0;
            r_data_bus       <= 16'd0;
            r_busy           <= 1'b0;
            r_timeout        <= 1'b0;
        end else begin
            r_msg_valid <= 1'b0;
            r_ltsm_ack  <= 1'b0;
            r_rdi_ack   <= 1'b0;
            r_timeout   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant_rdi <= ~w_grant_ltsm;
                        if (w_grant_ltsm) begin
                            r_data_valid <= i_ltsm_data_valid;
                            r_state_f    <= i_ltsm_state;
                            r_sub_state  <= i_ltsm_sub_state;
                            r_msg_no     <= i_ltsm_msg_no;
                            r_data_bus   <= i_ltsm_data_bus;
                        end else begin
                            // RDI messages carry no data and no state fields.
                            r_data_valid <= 1'b0;
                            r_state_f    <= 4'd0;
                            r_sub_state  <= 4'd0;
                            r_msg_no     <= i_rdi_msg_no;
                            r_data_bus   <= 16'd0;
                        end
                        r_msg_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= TO_LD;
                    r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (i_frame_done) begin
                        r_ltsm_ack       <= ~r_grant_rdi;
                        r_rdi_ack        <= r_grant_rdi;
                        r_last_grant_rdi <= r_grant_rdi;
                        r_cnt            <= GAP_LD;
                        if (GAP_CYCLES == 0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end else if (r_cnt <= ONE) begin
                        // Watchdog: give up the slot, the request stays pending.
                        r_timeout        <= 1'b1;
                        r_last_grant_rdi <= r_grant_rdi;
                        r_cnt            <= GAP_LD;
                        r_state          <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt - ONE;
                    end
                end
                S_GAP: begin
                    if (r_cnt <= ONE) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ltsm_ack   = r_ltsm_ack;
    assign o_rdi_ack    = r_rdi_ack;
    assign o_msg_valid  = r_msg_valid;
    assign o_data_valid = r_data_valid;
    assign o_state      = r_state_f;
    assign o_sub_state  = r_sub_state;
    assign o_msg_no     = r_msg_no;
    assign o_data_bus   = r_data_bus;
    assign o_busy       = r_busy;
    assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_sb_tx_msg_scheduler.sv
// Directed bench for sb_tx_msg_scheduler (GAP_CYCLES=4, TIMEOUT_CYCLES=8).
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_sb_tx_msg_scheduler;

    localparam int G = 4;
    localparam int T = 8;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_ltsm_req;
    logic [3:0]  i_ltsm_state;
    logic [3:0]  i_ltsm_sub_state;
    logic [3:0]  i_ltsm_msg_no;
    logic        i_ltsm_data_valid;
    logic [15:0] i_ltsm_data_bus;
    logic        o_ltsm_ack;
    logic        i_rdi_req;
    logic [3:0]  i_rdi_msg_no;
    logic        o_rdi_ack;
    logic        o_msg_valid;
    logic        o_data_valid;
    logic [3:0]  o_state;
    logic [3:0]  o_sub_state;
    logic [3:0]  o_msg_no;
    logic [15:0] o_data_bus;
    logic        i_frame_done;
    logic        o_busy;
    logic        o_timeout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ltsm_acks = 0;
    int rdi_acks = 0;
    int timeouts = 0;

    sb_tx_msg_scheduler #(
        .GAP_CYCLES(G), .TIMEOUT_CYCLES(T), .CNT_W(8)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_ltsm_req(i_ltsm_req), .i_ltsm_state(i_ltsm_state),
        .i_ltsm_sub_state(i_ltsm_sub_state), .i_ltsm_msg_no(i_ltsm_msg_no),
        .i_ltsm_data_valid(i_ltsm_data_valid), .i_ltsm_data_bus(i_ltsm_data_bus),
        .o_ltsm_ack(o_ltsm_ack), .i_rdi_req(i_rdi_req), .i_rdi_msg_no(i_rdi_msg_no),
        .o_rdi_ack(o_rdi_ack), .o_msg_valid(o_msg_valid), .o_data_valid(o_data_valid),
        .o_state(o_state), .o_sub_state(o_sub_state), .o_msg_no(o_msg_no),
        .o_data_bus(o_data_bus), .i_frame_done(i_frame_done), .o_busy(o_busy),
        .o_timeout(o_timeout)
    );

    // Clock and cycle counter.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Pulse monitors.
    always @(negedge i_clk) begin
        if (o_ltsm_ack) ltsm_acks <= ltsm_acks + 1;
        if (o_rdi_ack)  rdi_acks  <= rdi_acks + 1;
        if (o_timeout)  timeouts  <= timeouts + 1;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until o_msg_valid is seen (bounded); reports the cycle it was seen.
    task automatic wait_valid(output int c, output bit ok);
        ok = 1'b0;
        c  = 0;
        for (int i = 0; i < 30; i++) begin
            if (o_msg_valid) begin
                ok = 1'b1;
                c  = cyc;
                return;
            end
            tick();
        end
    endtask

    // From the issue cycle: move into WAIT_DONE and pulse frame_done at once.
    task automatic frame_done_now();
        tick();
        i_frame_done = 1'b1;
        tick();
        i_frame_done = 1'b0;
    endtask

    task automatic apply_reset();
        i_rst_n = 1'b0;
        ticks(2);
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        #2;
        checks++;
        if ({o_msg_valid, o_busy, o_ltsm_ack, o_rdi_ack, o_timeout, o_data_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000",
                     {o_msg_valid, o_busy, o_ltsm_ack, o_rdi_ack, o_timeout, o_data_valid});
        end
        checks++;
        if ({o_state, o_sub_state, o_msg_no, o_data_bus} !== 28'd0) begin
            errors++;
            $display("FAIL reset_fields got %h want 0", {o_state, o_sub_state, o_msg_no, o_data_bus});
        end
        ticks(2);
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ltsm_only();
        int a0;
        a0 = rdi_acks;
        i_ltsm_state = 4'd3; i_ltsm_sub_state = 4'd0; i_ltsm_msg_no = 4'd2;
        i_ltsm_data_valid = 1'b1; i_ltsm_data_bus = 16'h07FF;
        i_ltsm_req = 1'b1;
        tick();
        checks++;
        if (o_msg_valid !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL ltsm_issue valid=%b busy=%b want 1 1", o_msg_valid, o_busy);
        end
        checks++;
        if ({o_state, o_sub_state, o_msg_no, o_data_valid, o_data_bus} !== {4'd3, 4'd0, 4'd2, 1'b1, 16'h07FF}) begin
            errors++;
            $display("FAIL ltsm_fields got st=%0d sub=%0d msg=%0d dv=%b data=%h want 3 0 2 1 07ff",
                     o_state, o_sub_state, o_msg_no, o_data_valid, o_data_bus);
        end
        // Fields after grant must not follow the inputs.
        i_ltsm_data_bus = 16'h1234;
        tick();
        checks++;
        if (o_msg_valid !== 1'b0 || o_data_bus !== 16'h07FF) begin
            errors++;
            $display("FAIL ltsm_hold valid=%b data=%h want 0 07ff", o_msg_valid, o_data_bus);
        end
        ticks(2);
        i_frame_done = 1'b1;
        tick();
        i_frame_done = 1'b0;
        checks++;
        if (o_ltsm_ack !== 1'b1 || o_rdi_ack !== 1'b0) begin
            errors++;
            $display("FAIL ltsm_ack ltsm=%b rdi=%b want 1 0", o_ltsm_ack, o_rdi_ack);
        end
        i_ltsm_req = 1'b0;
        tick();
        checks++;
        if (o_ltsm_ack !== 1'b0) begin
            errors++;
            $display("FAIL ltsm_ack_width ack=%b want 0", o_ltsm_ack);
        end
        ticks(8);
        checks++;
        if (rdi_acks != a0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL ltsm_after rdi_acks=%0d busy=%b want %0d 0", rdi_acks, o_busy, a0);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_no [3];
        logic       exp_rdi [3];
        int c, prev;
        bit ok;
        apply_reset();
        exp_no[0] = 4'd4; exp_rdi[0] = 1'b0;
        exp_no[1] = 4'd9; exp_rdi[1] = 1'b1;
        exp_no[2] = 4'd4; exp_rdi[2] = 1'b0;
        i_ltsm_state = 4'd5; i_ltsm_sub_state = 4'd1; i_ltsm_msg_no = 4'd4;
        i_ltsm_data_valid = 1'b1; i_ltsm_data_bus = 16'hABCD;
        i_rdi_msg_no = 4'd9;
        i_ltsm_req = 1'b1; i_rdi_req = 1'b1;
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            wait_valid(c, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rr_issue_%0d no o_msg_valid within budget", k);
            end
            checks++;
            if (o_msg_no !== exp_no[k]) begin
                errors++;
                $display("FAIL rr_order_%0d msg_no=%0d want %0d", k, o_msg_no, exp_no[k]);
            end
            if (exp_rdi[k]) begin
                checks++;
                if (o_data_valid !== 1'b0 || o_data_bus !== 16'd0 || o_state !== 4'd0 || o_sub_state !== 4'd0) begin
                    errors++;
                    $display("FAIL rr_rdi_fields dv=%b data=%h st=%0d sub=%0d want 0 0 0 0",
                             o_data_valid, o_data_bus, o_state, o_sub_state);
                end
            end
            if (k > 0) begin
                checks++;
                if (c - prev != G + 3) begin
                    errors++;
                    $display("FAIL rr_spacing_%0d got %0d cycles want %0d", k, c - prev, G + 3);
                end
            end
            prev = c;
            frame_done_now();
            checks++;
            if (o_ltsm_ack !== ~exp_rdi[k] || o_rdi_ack !== exp_rdi[k]) begin
                errors++;
                $display("FAIL rr_ack_%0d ltsm=%b rdi=%b want %b %b", k, o_ltsm_ack, o_rdi_ack,
                         ~exp_rdi[k], exp_rdi[k]);
            end
        end
        i_ltsm_req = 1'b0; i_rdi_req = 1'b0;
        ticks(10);
    endtask

    task automatic test_gap_hold();
        int c;
        bit ok;
        i_rdi_msg_no = 4'd6;
        i_rdi_req = 1'b1;
        wait_valid(c, ok);
        frame_done_now();
        checks++;
        if (o_rdi_ack !== 1'b1) begin
            errors++;
            $display("FAIL gap_ack rdi_ack=%b want 1", o_rdi_ack);
        end
        for (int k = 0; k < G; k++) begin
            tick();
            checks++;
            if (o_msg_valid !== 1'b0) begin
                errors++;
                $display("FAIL gap_no_issue_%0d o_msg_valid=%b want 0", k, o_msg_valid);
            end
        end
        tick();
        checks++;
        if (o_msg_valid !== 1'b1) begin
            errors++;
            $display("FAIL gap_reissue o_msg_valid=%b want 1 at frame_done+6", o_msg_valid);
        end
        frame_done_now();
        i_rdi_req = 1'b0;
        ticks(10);
    endtask

    task automatic test_timeout();
        int c, issue_c, to_c, la0, ra0;
        bit ok, seen;
        la0 = ltsm_acks; ra0 = rdi_acks;
        i_ltsm_state = 4'd2; i_ltsm_sub_state = 4'd7; i_ltsm_msg_no = 4'd11;
        i_ltsm_data_valid = 1'b0; i_ltsm_data_bus = 16'h0000;
        i_rdi_msg_no = 4'd13;
        i_ltsm_req = 1'b1;
        wait_valid(issue_c, ok);
        checks++;
        if (!ok || o_msg_no !== 4'd11) begin
            errors++;
            $display("FAIL to_issue ok=%b msg_no=%0d want 1 11", ok, o_msg_no);
        end
        i_rdi_req = 1'b1;
        seen = 1'b0;
        to_c = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (o_timeout) begin
                seen = 1'b1;
                to_c = cyc;
            end
        end
        checks++;
        if (!seen || to_c - issue_c != T + 1) begin
            errors++;
            $display("FAIL to_pulse seen=%b delay=%0d want 1 %0d", seen, to_c - issue_c, T + 1);
        end
        tick();
        checks++;
        if (ltsm_acks != la0 || rdi_acks != ra0) begin
            errors++;
            $display("FAIL to_no_ack ltsm_acks=%0d rdi_acks=%0d want %0d %0d", ltsm_acks, rdi_acks, la0, ra0);
        end
        wait_valid(c, ok);
        checks++;
        if (!ok || o_msg_no !== 4'd13) begin
            errors++;
            $display("FAIL to_other_first ok=%b msg_no=%0d want 1 13", ok, o_msg_no);
        end
        frame_done_now();
        checks++;
        if (o_rdi_ack !== 1'b1) begin
            errors++;
            $display("FAIL to_rdi_ack rdi_ack=%b want 1", o_rdi_ack);
        end
        i_rdi_req = 1'b0;
        wait_valid(c, ok);
        checks++;
        if (!ok || o_msg_no !== 4'd11) begin
            errors++;
            $display("FAIL to_reissue ok=%b msg_no=%0d want 1 11", ok, o_msg_no);
        end
        frame_done_now();
        checks++;
        if (o_ltsm_ack !== 1'b1) begin
            errors++;
            $display("FAIL to_ltsm_ack ltsm_ack=%b want 1", o_ltsm_ack);
        end
        i_ltsm_req = 1'b0;
        ticks(10);
    endtask

    task automatic test_reset_mid();
        int c, la0;
        bit ok;
        i_ltsm_state = 4'd1; i_ltsm_sub_state = 4'd2; i_ltsm_msg_no = 4'd3;
        i_ltsm_data_valid = 1'b1; i_ltsm_data_bus = 16'h5A5A;
        i_ltsm_req = 1'b1;
        wait_valid(c, ok);
        ticks(3);
        la0 = ltsm_acks;
        i_rst_n = 1'b0;
        #2;
        checks++;
        if ({o_msg_valid, o_busy, o_ltsm_ack, o_rdi_ack, o_timeout, o_data_valid} !== 6'b0 ||
            {o_state, o_sub_state, o_msg_no, o_data_bus} !== 28'd0) begin
            errors++;
            $display("FAIL rst_mid_clear flags=%b fields=%h want 0 0",
                     {o_msg_valid, o_busy, o_ltsm_ack, o_rdi_ack, o_timeout, o_data_valid},
                     {o_state, o_sub_state, o_msg_no, o_data_bus});
        end
        i_frame_done = 1'b1;
        ticks(2);
        i_frame_done = 1'b0;
        i_rst_n = 1'b1;
        ticks(3);
        checks++;
        if (ltsm_acks != la0) begin
            errors++;
            $display("FAIL rst_mid_no_ack ltsm_acks=%0d want %0d", ltsm_acks, la0);
        end
        wait_valid(c, ok);
        checks++;
        if (!ok || o_msg_no !== 4'd3 || o_data_bus !== 16'h5A5A) begin
            errors++;
            $display("FAIL rst_mid_reissue ok=%b msg_no=%0d data=%h want 1 3 5a5a", ok, o_msg_no, o_data_bus);
        end
        frame_done_now();
        checks++;
        if (o_ltsm_ack !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_ack ltsm_ack=%b want 1", o_ltsm_ack);
        end
        i_ltsm_req = 1'b0;
        ticks(10);
    endtask

    task automatic test_stray_frame_done();
        int ra0;
        ra0 = rdi_acks;
        i_frame_done = 1'b1;
        tick();
        i_frame_done = 1'b0;
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_rdi_ack !== 1'b0 || o_ltsm_ack !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle busy=%b rdi=%b ltsm=%b want 0 0 0", o_busy, o_rdi_ack, o_ltsm_ack);
        end
        i_rdi_msg_no = 4'd5;
        i_rdi_req = 1'b1;
        tick();
        checks++;
        if (o_msg_valid !== 1'b1) begin
            errors++;
            $display("FAIL stray_issue o_msg_valid=%b want 1", o_msg_valid);
        end
        // Pulse lands on the ISSUE edge and must be ignored.
        i_frame_done = 1'b1;
        tick();
        i_frame_done = 1'b0;
        ticks(3);
        checks++;
        if (rdi_acks != ra0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL stray_issue_ignored rdi_acks=%0d busy=%b want %0d 1", rdi_acks, o_busy, ra0);
        end
        i_frame_done = 1'b1;
        tick();
        i_frame_done = 1'b0;
        checks++;
        if (o_rdi_ack !== 1'b1 || o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL stray_genuine rdi_ack=%b timeout=%b want 1 0", o_rdi_ack, o_timeout);
        end
        i_rdi_req = 1'b0;
        ticks(10);
    endtask

    initial begin
        i_rst_n = 1'b1;
        i_ltsm_req = 1'b0; i_ltsm_state = 4'd0; i_ltsm_sub_state = 4'd0;
        i_ltsm_msg_no = 4'd0; i_ltsm_data_valid = 1'b0; i_ltsm_data_bus = 16'd0;
        i_rdi_req = 1'b0; i_rdi_msg_no = 4'd0; i_frame_done = 1'b0;
        #3;
        test_reset();
        test_ltsm_only();
        test_round_robin();
        test_gap_hold();
        test_timeout();
        test_reset_mid();
        test_stray_frame_done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
